// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin bus arbiter between the CPU and NUM_CH bus-master
//             channels. Requests the bus from the CPU (CPU_Hold/CPU_Ack),
//             then grants one channel at a time until no eligible request
//             remains, after which the bus is handed back to the CPU.
//  Options  : ARB_TIMEOUT_EN - when defined, a grant is revoked after
//             MAX_HOLD cycles and the offending channel is masked until its
//             request drops. When undefined, grants are held indefinitely and
//             Timeout is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter  int NUM_CH   = 2,
    parameter  int MAX_HOLD = 256,
    localparam int IDW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NUM_CH-1:0] Req,
    output logic [NUM_CH-1:0] Gnt,
    output logic [IDW-1:0]    Gnt_Id,
    output logic              CPU_Hold,
    input  logic              CPU_Ack,
    output logic              Busy,
    output logic              Timeout
);

    // Control states. RELEASE waits for the CPU to withdraw its acknowledge.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_BUS = 3'd1,
        S_GRANT   = 3'd2,
        S_ARB     = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;     // most recently granted channel

    // Output registers: the visible outputs trail the state by one cycle.
    logic [NUM_CH-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               hold_q, hold_d;
    logic               timeout_q, timeout_d;

    logic [NUM_CH-1:0]  elig;               // requests allowed to compete
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     rr_idx;
    logic               cur_req;            // request of the granted channel
    logic               abort;              // CPU withdrew the bus mid-grant
    logic               to_fire;            // hold limit reached this cycle
    logic               to_pend;            // revocation happened last edge

    // Wrap-around increment over the channel index range.
    function automatic logic [IDW-1:0] nxt_idx(input logic [IDW-1:0] x);
        if (x == IDW'(NUM_CH - 1)) begin
            return '0;
        end
        return x + IDW'(1);
    endfunction

    assign cur_req = Req[last_q];
    assign abort   = (state_q == S_GRANT) && !CPU_Ack;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0]        hold_cnt_q, hold_cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               to_q;

    assign elig    = Req & ~mask_q;
    assign to_fire = (state_q == S_GRANT) && CPU_Ack && cur_req &&
                     (hold_cnt_q == HOLD_LAST);
    assign to_pend = to_q;

    // Hold counter restarts on every grant entry; masks follow revocations.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if ((state_q != S_GRANT) && (state_d == S_GRANT)) begin
            hold_cnt_d = '0;
        end else if (state_q == S_GRANT) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
        end

        // A masked channel stays masked only while it keeps requesting.
        mask_d = mask_q & Req;
        if (to_fire) begin
            mask_d[last_q] = 1'b1;
        end
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_cnt_q <= '0;
            mask_q     <= '0;
            to_q       <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
            to_q       <= to_fire;
        end
    end
`else
    logic [15:0] unused_max_hold;

    assign elig            = Req;
    assign to_fire         = 1'b0;
    assign to_pend         = 1'b0;
    assign unused_max_hold = 16'(MAX_HOLD);
`endif

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = nxt_idx(last_q);
        for (int k = 0; k < NUM_CH; k++) begin
            if (!win_found && elig[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
            rr_idx = nxt_idx(rr_idx);
        end
    end

    // Next-state logic; the pointer moves whenever a new grant is issued.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    state_d = S_REQ_BUS;
                end
            end
            S_REQ_BUS: begin
                if (!win_found) begin
                    state_d = S_RELEASE;
                end else if (CPU_Ack) begin
                    state_d = S_GRANT;
                    last_d  = win_idx;
                end
            end
            S_GRANT: begin
                if (!CPU_Ack) begin
                    state_d = S_RELEASE;
                end else if (!cur_req || to_fire) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (!CPU_Ack || !win_found) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_GRANT;
                    last_d  = win_idx;
                end
            end
            S_RELEASE: begin
                if (!CPU_Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; an abort drops the grant without the usual delay.
    always_comb begin
        gnt_d    = '0;
        gnt_id_d = '0;
        if ((state_q == S_GRANT) && !abort) begin
            gnt_d[last_q] = 1'b1;
            gnt_id_d      = last_q;
        end
        hold_d    = (state_q == S_REQ_BUS) || (state_q == S_GRANT) ||
                    (state_q == S_ARB);
        timeout_d = to_pend;
    end

    // State and pointer registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            hold_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign Gnt      = gnt_q;
    assign Gnt_Id   = gnt_id_q;
    assign CPU_Hold = hold_q;
    assign Timeout  = timeout_q;
    assign Busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised bus arbiter between the CPU and `NUM_CH` bus-master channels (DMA RX, DMA TX, future masters), generalising the single-channel `DMA_Req`/`DMA_Ack` bus-grant handshake.
- Collects channel requests and asks the CPU to release its RAM/databus via `CPU_Hold`.
- After the CPU acknowledges, grants exactly one channel at a time in round-robin order.
- Optionally revokes grants that exceed a hold limit.
- Sits between the `cpu` bus-grant ports and the DMA/peripheral masters at top level.

## Interface
- `NUM_CH`, 2: number of requesting channels, 1..8.
- `MAX_HOLD`, 256: maximum grant length in cycles, 2..65535; used only with `ARB_TIMEOUT_EN`.
- `IDW`, `$clog2(NUM_CH)` (minimum 1): width of `Gnt_Id`; localparam.
- `Clk`, in, 1: system clock, rising edge.
- `Rst_n`, in, 1: asynchronous active-low reset.
- `Req`, in, `NUM_CH`: per-channel bus request, level; held high for the whole transfer.
- `Gnt`, out, `NUM_CH`: one-hot grant, registered.
- `Gnt_Id`, out, `IDW`: index of the granted channel; valid while `|Gnt`.
- `CPU_Hold`, out, 1: bus release request to the CPU; drives `cpu.DMA_Req`.
- `CPU_Ack`, in, 1: CPU bus release acknowledge, from `cpu.DMA_Ack`.
- `Busy`, out, 1: high in any state other than IDLE.
- `Timeout`, out, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- FSM has four states: IDLE, REQ_BUS, GRANT, ARB. A fifth state, RELEASE, handles bus return.
- IDLE:
  - `|Req` → REQ_BUS.
- REQ_BUS: `CPU_Hold`=1.
  - `CPU_Ack`=1 → GRANT with the round-robin winner.
  - `Req` all drop before `CPU_Ack` → RELEASE.
- Round robin:
  - Pointer `last` holds the most recently granted index.
  - Search starts at `last+1` mod `NUM_CH`; first set bit wins.
  - `last` updates on every grant.
  - Reset value of `last` is `NUM_CH-1`, so channel 0 wins the first tie.
- GRANT: `Gnt[w]`=1, `Gnt_Id`=w, `CPU_Hold`=1.
  - `Req[w]`=0 → ARB.
- ARB: one cycle with `Gnt`=0 and `CPU_Hold`=1.
  - Any eligible `Req` → GRANT with the next winner. Back-to-back grants do not return the bus to the CPU.
  - No eligible `Req` → RELEASE.
- RELEASE: `CPU_Hold`=0.
  - `CPU_Ack`=0 → IDLE.
  - New requests wait until IDLE.
- `CPU_Ack` falling in GRANT or ARB is a protocol abort:
  - `Gnt` clears on the next edge.
  - State → RELEASE.
- Channel masking: a channel is ineligible while its mask bit is set.
  - The mask bit is set by revocation.
  - The mask bit clears when that channel's `Req` is low.
- `Busy` = (state != IDLE).

## Timing
- Reset values: `Gnt`=0, `Gnt_Id`=0, `CPU_Hold`=0, `Busy`=0, `Timeout`=0, `last`=`NUM_CH-1`, hold counter 0, mask 0, state IDLE.
- Reset is asynchronous and may occur mid-grant. All outputs go to their reset values immediately, with no release handshake.
- Request latency: `Req` high at edge n → `CPU_Hold` high after edge n+1.
- Grant latency: `CPU_Ack` sampled high at edge m → `Gnt` high after edge m+1.
- Release: `Req[w]` sampled low at edge k → `Gnt` low after edge k+1 → next `Gnt` after edge k+2 if a request is pending.
- Otherwise `CPU_Hold` low after edge k+2.
- `Req` changes from non-granted channels during GRANT are ignored until ARB.
- Simultaneous release by the granted channel and a new request by another channel: the new request is served in ARB.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A 16-bit hold counter clears on entry to GRANT and increments every GRANT cycle.
  - On the cycle the count equals `MAX_HOLD-1`, the next edge clears `Gnt`, pulses `Timeout` for 1 cycle, sets the mask bit for w, and moves to ARB.
  - The grant therefore lasts exactly `MAX_HOLD` cycles.
  - A masked channel cannot be regranted until its `Req` drops.
- `ARB_TIMEOUT_EN` undefined:
  - No counter and no mask logic.
  - `Timeout` is tied to 0.
  - A grant is held indefinitely; `MAX_HOLD` is unused.

## Test plan
- Single request, `NUM_CH`=2:
  - Stimulus: `Req`=01, CPU acks 3 cycles later, channel holds 10 cycles, then drops.
  - Response: `CPU_Hold` 1 cycle after `Req`; `Gnt`=01 1 cycle after `CPU_Ack`; `Gnt`=00 1 cycle after drop; `CPU_Hold`=0 the cycle after.
- Round robin, `NUM_CH`=4:
  - Stimulus: `Req`=1111 held; each grantee drops after 5 cycles and re-raises.
  - Response: grant order 0,1,2,3,0, with a 1-cycle gap and `CPU_Hold` continuously high.
- Back-to-back:
  - Stimulus: channel 1 raises `Req` while channel 0 is granted.
  - Response: after channel 0 drops, `Gnt`=10 two cycles later, `CPU_Hold` never drops, and no new `CPU_Ack` handshake occurs.
- Abort:
  - Stimulus: `CPU_Ack` drops during GRANT.
  - Response: `Gnt`=0 next cycle; `CPU_Hold`=0 the cycle after; then IDLE.
- Timeout, `ARB_TIMEOUT_EN`, `MAX_HOLD`=8:
  - Stimulus: channel 0 never drops; channel 1 requests.
  - Response: `Gnt`=01 for exactly 8 cycles; 1-cycle `Timeout` pulse; `Gnt`=10 next.
  - Stimulus: after channel 1 drops, channel 0 is still high.
  - Response: channel 0 is not regranted; release to CPU.
- Reset mid-grant:
  - Stimulus: assert `Rst_n`=0 asynchronously while `Gnt`=01.
  - Response: all outputs 0 immediately; after deassertion, the first grant goes to channel 0.
